pipe_reg_chain: RTL and testbench

//   Parametrised multi-lane register pipeline with valid/ready flow control.

---
 rtl/npu_pipe_pkg.sv | 24 ++
 rtl/pipe_reg_chain_if.sv | 30 +++
 rtl/pipe_stage.sv | 33 +++
 rtl/pipe_reg_chain.sv | 79 +++++++
 tb/tb_pipe_reg_chain.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/npu_pipe_pkg.sv
// Shared helpers for NPU pipeline blocks: width arithmetic used to size beats and counters.
package npu_pipe_pkg;

  // Ceiling log2; returns 0 for v <= 1.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    int unsigned val;
    r = 0;
    if (v > 1) begin
      val = v - 1;
      while (val > 0) begin
        r++;
        val = val >> 1;
      end
    end
    return r;
  endfunction

  // Total bits in one multi-lane beat.
  function automatic int unsigned beat_w(input int unsigned lanes, input int unsigned width);
    return lanes * width;
  endfunction

endpackage

// File: rtl/pipe_reg_chain_if.sv
// Valid/ready beat bus plus flush and occupancy for the register pipeline.
interface pipe_reg_chain_if
  import npu_pipe_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned LANES = 4,
  parameter int unsigned DEPTH = 3
);
  localparam int unsigned BEAT_W = beat_w(LANES, WIDTH);
  localparam int unsigned CNT_W  = clog2(DEPTH + 1);

  logic              flush_i;
  logic              in_valid_i;
  logic              in_ready_o;
  logic [BEAT_W-1:0] in_data_i;
  logic              out_valid_o;
  logic              out_ready_i;
  logic [BEAT_W-1:0] out_data_o;
  logic [CNT_W-1:0]  count_o;

  modport master (
    output flush_i, in_valid_i, in_data_i, out_ready_i,
    input  in_ready_o, out_valid_o, out_data_o, count_o
  );

  modport slave (
    input  flush_i, in_valid_i, in_data_i, out_ready_i,
    output in_ready_o, out_valid_o, out_data_o, count_o
  );
endinterface

// File: rtl/pipe_stage.sv
// One pipeline stage: valid bit plus beat data, data only loaded when a real beat arrives.
module pipe_stage #(
  parameter int unsigned BEAT_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              en,
  input  logic              load,
  input  logic              valid_in,
  input  logic [BEAT_W-1:0] data_in,
  output logic              valid,
  output logic [BEAT_W-1:0] data
);

  // Flush clears only the valid bit; data keeps its last value.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= '0;
    end else begin
      if (clr) begin
        valid <= 1'b0;
      end else if (en) begin
        valid <= valid_in;
      end
      if (load) begin
        data <= data_in;
      end
    end
  end

endmodule

// File: rtl/pipe_reg_chain.sv
// Multi-lane register pipeline with valid/ready flow control, bubble collapsing and flush.
module pipe_reg_chain
  import npu_pipe_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned LANES = 4,
  parameter int unsigned DEPTH = 3
) (
  input logic             clk,
  input logic             rst,
  pipe_reg_chain_if.slave bus
);

  localparam int unsigned BEAT_W = beat_w(LANES, WIDTH);
  localparam int unsigned CNT_W  = clog2(DEPTH + 1);

  if (DEPTH < 1) begin : g_depth_chk
    $error("pipe_reg_chain: DEPTH must be >= 1");
  end

  logic [DEPTH-1:0]  v;
  logic [DEPTH-1:0]  adv;
  logic [DEPTH-1:0]  vin;
  logic [DEPTH-1:0]  load;
  logic [BEAT_W-1:0] d [DEPTH];
  logic              in_xfer;
  logic [CNT_W-1:0]  cnt;

  // Ready ripples back from the output; an empty stage always advances.
  always_comb begin
    adv = '0;
    adv[DEPTH-1] = bus.out_ready_i | ~v[DEPTH-1];
    for (int k = int'(DEPTH) - 2; k >= 0; k--) begin
      adv[k] = adv[k+1] | ~v[k];
    end
  end

  assign bus.in_ready_o = adv[0] & ~bus.flush_i;
  assign in_xfer        = bus.in_valid_i & bus.in_ready_o;

  for (genvar k = 0; k < int'(DEPTH); k++) begin : g_stage
    logic [BEAT_W-1:0] din;

    if (k == 0) begin : g_first
      assign vin[k] = in_xfer;
      assign din    = bus.in_data_i;
    end else begin : g_rest
      assign vin[k] = v[k-1];
      assign din    = d[k-1];
    end

    assign load[k] = adv[k] & vin[k] & ~bus.flush_i;

    pipe_stage #(.BEAT_W(BEAT_W)) u_stage (
      .clk      (clk),
      .rst      (rst),
      .clr      (bus.flush_i),
      .en       (adv[k]),
      .load     (load[k]),
      .valid_in (vin[k]),
      .data_in  (din),
      .valid    (v[k]),
      .data     (d[k])
    );
  end

  // Occupancy is a pure function of the stage valid registers.
  always_comb begin
    cnt = '0;
    for (int k = 0; k < int'(DEPTH); k++) begin
      cnt = cnt + CNT_W'(v[k]);
    end
  end

  assign bus.out_valid_o = v[DEPTH-1];
  assign bus.out_data_o  = d[DEPTH-1];
  assign bus.count_o     = cnt;

endmodule

// File: tb/tb_pipe_reg_chain.sv
// Directed bench for pipe_reg_chain (WIDTH=16, LANES=4, DEPTH=3).
module tb_pipe_reg_chain;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned LANES = 4;
  localparam int unsigned DEPTH = 3;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;

  pipe_reg_chain_if #(.WIDTH(WIDTH), .LANES(LANES), .DEPTH(DEPTH)) bus ();

  pipe_reg_chain #(.WIDTH(WIDTH), .LANES(LANES), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Each lane carries a distinct offset of the lane-0 value.
  function automatic logic [63:0] mk(input logic [15:0] x);
    logic [15:0] l1, l2, l3;
    l1 = x + 16'h1000;
    l2 = x + 16'h2000;
    l3 = x + 16'h3000;
    return {l3, l2, l1, x};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic vld, input logic [63:0] data);
    bus.in_valid_i = vld;
    bus.in_data_i  = data;
    #1;
  endtask

  task automatic chk_state(input string tag, input logic ov, input logic [63:0] od,
                           input logic [1:0] cnt, input logic rdy);
    chk({tag, ".out_valid"}, 64'(bus.out_valid_o), 64'(ov));
    chk({tag, ".out_data"},  bus.out_data_o,       od);
    chk({tag, ".count"},     64'(bus.count_o),     64'(cnt));
    chk({tag, ".in_ready"},  64'(bus.in_ready_o),  64'(rdy));
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst             = 1'b1;
    bus.flush_i     = 1'b0;
    bus.in_valid_i  = 1'b0;
    bus.in_data_i   = '0;
    bus.out_ready_i = 1'b0;

    // 1: reset state
    cyc();
    cyc();
    chk_state("reset", 1'b0, 64'h0, 2'd0, 1'b1);
    rst = 1'b0;
    cyc();

    // 2: streaming, latency 3, one beat per cycle
    bus.out_ready_i = 1'b1;
    for (int c = 0; c < 8; c++) begin
      if (c < 5) drive(1'b1, mk(16'(c + 1)));
      else       drive(1'b0, 64'h0);
      chk($sformatf("stream%0d.in_ready", c), 64'(bus.in_ready_o), 64'd1);
      chk($sformatf("stream%0d.out_valid", c), 64'(bus.out_valid_o), 64'(c >= 3));
      chk($sformatf("stream%0d.count", c), 64'(bus.count_o),
          64'((c <= 3) ? c : ((c <= 5) ? 3 : 8 - c)));
      if (c >= 3) chk($sformatf("stream%0d.out_data", c), bus.out_data_o, mk(16'(c - 2)));
      cyc();
    end
    chk_state("stream_empty", 1'b0, mk(16'h0005), 2'd0, 1'b1);

    // 3: backpressure, fill to full, drain+fill in same cycle
    bus.out_ready_i = 1'b0;
    drive(1'b1, mk(16'h00A1));
    chk("bp.a1_ready", 64'(bus.in_ready_o), 64'd1);
    cyc();
    drive(1'b1, mk(16'h00A2));
    chk("bp.a2_ready", 64'(bus.in_ready_o), 64'd1);
    cyc();
    drive(1'b1, mk(16'h00A3));
    chk("bp.a3_ready", 64'(bus.in_ready_o), 64'd1);
    cyc();
    drive(1'b1, mk(16'h00A4));
    chk_state("bp.full", 1'b1, mk(16'h00A1), 2'd3, 1'b0);
    cyc();
    chk_state("bp.stall", 1'b1, mk(16'h00A1), 2'd3, 1'b0);
    bus.out_ready_i = 1'b1;
    #1;
    chk("bp.release_ready", 64'(bus.in_ready_o), 64'd1);
    cyc();
    drive(1'b0, 64'h0);
    chk_state("bp.out_a2", 1'b1, mk(16'h00A2), 2'd3, 1'b1);
    cyc();
    chk_state("bp.out_a3", 1'b1, mk(16'h00A3), 2'd2, 1'b1);
    cyc();
    chk_state("bp.out_a4", 1'b1, mk(16'h00A4), 2'd1, 1'b1);
    cyc();
    chk_state("bp.empty", 1'b0, mk(16'h00A4), 2'd0, 1'b1);

    // 4: bubble collapse under output stall
    bus.out_ready_i = 1'b0;
    drive(1'b1, mk(16'h0B01));
    cyc();
    drive(1'b0, 64'h0);
    cyc();
    drive(1'b1, mk(16'h0B02));
    cyc();
    drive(1'b0, 64'h0);
    chk_state("bubble.gap", 1'b1, mk(16'h0B01), 2'd2, 1'b1);
    cyc();
    chk_state("bubble.packed", 1'b1, mk(16'h0B01), 2'd2, 1'b1);
    bus.out_ready_i = 1'b1;
    #1;
    chk("bubble.release_data", bus.out_data_o, mk(16'h0B01));
    cyc();
    chk_state("bubble.out_b", 1'b1, mk(16'h0B02), 2'd1, 1'b1);
    cyc();
    chk_state("bubble.empty", 1'b0, mk(16'h0B02), 2'd0, 1'b1);

    // 5: flush with full pipe and a pending input beat
    bus.out_ready_i = 1'b0;
    drive(1'b1, mk(16'h0C01));
    cyc();
    drive(1'b1, mk(16'h0C02));
    cyc();
    drive(1'b1, mk(16'h0C03));
    cyc();
    drive(1'b1, mk(16'hDEAD));
    chk("flush.full_count", 64'(bus.count_o), 64'd3);
    bus.flush_i = 1'b1;
    #1;
    chk("flush.in_ready", 64'(bus.in_ready_o), 64'd0);
    cyc();
    bus.flush_i = 1'b0;
    drive(1'b0, 64'h0);
    chk_state("flush.cleared", 1'b0, mk(16'h0C01), 2'd0, 1'b1);
    bus.out_ready_i = 1'b1;
    drive(1'b1, mk(16'hBEEF));
    chk("flush.beef_ready", 64'(bus.in_ready_o), 64'd1);
    cyc();
    drive(1'b0, 64'h0);
    chk("flush.t1_count", 64'(bus.count_o), 64'd1);
    cyc();
    chk("flush.t2_valid", 64'(bus.out_valid_o), 64'd0);
    cyc();
    chk_state("flush.beef_out", 1'b1, mk(16'hBEEF), 2'd1, 1'b1);
    cyc();
    chk_state("flush.beef_gone", 1'b0, mk(16'hBEEF), 2'd0, 1'b1);

    // 6: reset while full and stalled
    bus.out_ready_i = 1'b0;
    drive(1'b1, mk(16'h0D01));
    cyc();
    drive(1'b1, mk(16'h0D02));
    cyc();
    drive(1'b1, mk(16'h0D03));
    cyc();
    drive(1'b1, mk(16'h0D04));
    chk_state("midrst.full", 1'b1, mk(16'h0D01), 2'd3, 1'b0);
    rst = 1'b1;
    cyc();
    chk_state("midrst.cleared", 1'b0, 64'h0, 2'd0, 1'b1);
    rst = 1'b0;
    drive(1'b0, 64'h0);
    cyc();
    chk_state("midrst.after", 1'b0, 64'h0, 2'd0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
